// File: rtl/svc_soc_uart_pkg.sv
// Shared definitions for the UART receiver: RX state encoding,
// register offsets relative to BASE_ADDR, and STATUS bit positions.
// The PARITY state exists only when SVC_SOC_UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
package svc_soc_uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
`ifdef SVC_SOC_UART_RX_PARITY_EN
    RX_PARITY = 3'd3,
`endif
    RX_STOP   = 3'd4
  } rx_state_e;

  localparam logic [31:0] REG_DATA_OFF   = 32'h0;
  localparam logic [31:0] REG_STATUS_OFF = 32'h4;

  localparam int STAT_NEMPTY    = 0;
  localparam int STAT_OVERRUN   = 1;
  localparam int STAT_FRAME     = 2;
  localparam int STAT_PARITY    = 3;
  localparam int STAT_COUNT_LSB = 4;

endpackage

// File: rtl/svc_soc_uart_rx_fifo.sv
// Receive FIFO: power-of-two depth, wrapping pointers, combinational head.
// A push while full is accepted only when a pop happens in the same cycle.
`timescale 1ns/1ps
module svc_soc_uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem[rptr_q];

  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
  end

  // Storage write; no reset so the array maps onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= din_i;
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/svc_soc_uart_rx.sv
// UART 8N1 receiver with receive FIFO and a two-register I/O window
// (DATA at +0, STATUS at +4). Defining SVC_SOC_UART_RX_PARITY_EN adds an
// even-parity bit after the data bits and the parity_err sticky flag.
`timescale 1ns/1ps
module svc_soc_uart_rx
  import svc_soc_uart_pkg::*;
#(
  parameter int          CLOCK_FREQ = 100_000_000,
  parameter int          BAUD_RATE  = 115_200,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        urx_pin,
  input  logic        io_ren,
  input  logic [31:0] io_raddr,
  output logic [31:0] io_rdata,
  input  logic        io_wen,
  input  logic [31:0] io_waddr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wstrb
);

  localparam int DIV  = CLOCK_FREQ / BAUD_RATE;
  localparam int CW   = $clog2(DIV + 1);
  localparam int HALF = ((DIV / 2) < 1) ? 1 : (DIV / 2);
  localparam int FCW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIV);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [31:0] ADDR_DATA   = BASE_ADDR + REG_DATA_OFF;
  localparam logic [31:0] ADDR_STATUS = BASE_ADDR + REG_STATUS_OFF;

  logic            sync1_q, sync2_q, rx_s;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            expire;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_head;
  logic [FCW-1:0]  fifo_count;
  logic            overrun_q, overrun_d, overrun_set;
  logic            frame_q, frame_d, frame_set;
  logic            w1c_hit;
  logic [31:0]     status_word;
  logic [31:0]     rdata_q, rdata_d;
  logic            unused_ok;
`ifdef SVC_SOC_UART_RX_PARITY_EN
  logic            par_bad_q, par_bad_d;
  logic            parity_q, parity_d, parity_set;
`endif

  assign rx_s      = sync2_q;
  assign expire    = (cnt_q <= CW'(1));
  assign io_rdata  = rdata_q;
  assign unused_ok = ^{io_wdata, io_wstrb};

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= urx_pin;
      sync2_q <= sync1_q;
    end
  end

  // Receive FSM next-state: counter reloads, bit sampling and push/flag strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = expire ? cnt_q : (cnt_q - CW'(1));
    bit_d     = bit_q;
    shift_d   = shift_q;
    fifo_push = 1'b0;
    frame_set = 1'b0;
`ifdef SVC_SOC_UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    parity_set = 1'b0;
`endif
    unique case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          cnt_d   = CNT_HALF;
`ifdef SVC_SOC_UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      RX_START: begin
        if (expire) begin
          if (rx_s) begin
            state_d = RX_IDLE;          // false start: glitch on idle line
          end else begin
            state_d = RX_DATA;
            cnt_d   = CNT_FULL;
            bit_d   = 3'd0;
          end
        end
      end
      RX_DATA: begin
        if (expire) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = CNT_FULL;
          if (bit_q == 3'd7) begin
`ifdef SVC_SOC_UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef SVC_SOC_UART_RX_PARITY_EN
      RX_PARITY: begin
        if (expire) begin
          par_bad_d  = ^{shift_q, rx_s};
          parity_set = ^{shift_q, rx_s};
          cnt_d      = CNT_FULL;
          state_d    = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (expire) begin
          if (rx_s) begin
`ifdef SVC_SOC_UART_RX_PARITY_EN
            fifo_push = ~par_bad_q;
`else
            fifo_push = 1'b1;
`endif
          end else begin
            frame_set = 1'b1;
          end
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Receive FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef SVC_SOC_UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
`ifdef SVC_SOC_UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  svc_soc_uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .din_i   (shift_q),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Sticky flag next-state: W1C clear, with a same-cycle set taking priority.
  always_comb begin
    w1c_hit     = io_wen && (io_waddr == ADDR_STATUS) && io_wstrb[0];
    overrun_set = fifo_push & fifo_full & ~fifo_pop;
    overrun_d   = (overrun_q & ~(w1c_hit & io_wdata[STAT_OVERRUN])) | overrun_set;
    frame_d     = (frame_q & ~(w1c_hit & io_wdata[STAT_FRAME])) | frame_set;
`ifdef SVC_SOC_UART_RX_PARITY_EN
    parity_d    = (parity_q & ~(w1c_hit & io_wdata[STAT_PARITY])) | parity_set;
`endif
  end

  // Sticky flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
`ifdef SVC_SOC_UART_RX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      overrun_q <= overrun_d;
      frame_q   <= frame_d;
`ifdef SVC_SOC_UART_RX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Read mux: DATA pops the head when non-empty, STATUS is side-effect free.
  always_comb begin
    status_word                      = '0;
    status_word[STAT_NEMPTY]         = ~fifo_empty;
    status_word[STAT_OVERRUN]        = overrun_q;
    status_word[STAT_FRAME]          = frame_q;
`ifdef SVC_SOC_UART_RX_PARITY_EN
    status_word[STAT_PARITY]         = parity_q;
`endif
    status_word[STAT_COUNT_LSB +: 4] = 4'(fifo_count);

    rdata_d  = rdata_q;
    fifo_pop = 1'b0;
    if (io_ren) begin
      rdata_d = '0;
      if (io_raddr == ADDR_DATA) begin
        if (!fifo_empty) begin
          rdata_d  = {24'h0, fifo_head};
          fifo_pop = 1'b1;
        end
      end else if (io_raddr == ADDR_STATUS) begin
        rdata_d = status_word;
      end
    end
  end

  // Registered read data.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

endmodule
